regfile_wb_scheduler: RTL and testbench
=======================================

Name: regfile_wb_scheduler

Overview:
- Controls the decode-stage register file of the 5-stage pipeline.
- Two jobs:
  - Arbitrates the single register-file write port between the ALU writeback source and the memory-load writeback source, using a one-entry holding buffer.
  - Keeps a per-register scoreboard of in-flight writes and raises a decode stall on RAW hazards.
- Sits beside the register file: drives its write port and consumes decode-stage issue info.

Parameters:
- DATA_WIDTH, 16, register data width
- ADDR_WIDTH, 3, register index width (2**ADDR_WIDTH registers)
- PEND_WIDTH, 2, width of each per-register pending-write counter (max in flight = 2**PEND_WIDTH-1)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- issue_valid  in  1  decode stage presents an instruction
- issue_writes  in  1  instruction writes a destination register
- issue_dst  in  ADDR_WIDTH  destination register index
- src1_used, src2_used  in  1 each  source operand is read
- src1, src2  in  ADDR_WIDTH each  source register indices
- stall  out  1  decode must hold; issue not recorded (combinational)
- alu_wb_valid  in  1  ALU result available
- alu_wb_addr  in  ADDR_WIDTH  ALU result register index
- alu_wb_data  in  DATA_WIDTH  ALU result
- alu_wb_ready  out  1  ALU result accepted this cycle (combinational)
- mem_wb_valid  in  1  load result available; always accepted, no ready
- mem_wb_addr  in  ADDR_WIDTH  load result register index
- mem_wb_data  in  DATA_WIDTH  load result
- rf_write_enable  out  1  register-file write enable (registered)
- rf_write_address  out  ADDR_WIDTH  register-file write address (registered)
- rf_write_data  out  DATA_WIDTH  register-file write data (registered)

Behaviour:
- Reset (rst=1 at edge):
  - all pending counters = 0; buffer empty
  - rf_write_enable = 0, rf_write_address = 0, rf_write_data = 0
  - any in-flight request is dropped
- Write-port arbitration each cycle, priority mem > buffer > alu.
  - mem_wb_valid: mem wins. If alu_wb_valid and buffer empty, ALU result loads buffer. If buffer full, alu_wb_ready = 0 and the ALU source holds.
  - No mem, buffer full: buffer wins. A simultaneous valid ALU result is accepted into the buffer (refill).
  - No mem, buffer empty, alu_wb_valid: ALU wins directly.
  - alu_wb_ready = alu_wb_valid & (!buffer_full | !mem_wb_valid).
- Write-port timing:
  - Winner is registered onto rf_write_* at the next edge: 1-cycle latency from acceptance to rf_write_enable high.
  - The register file captures it at the following edge.
  - rf_write_enable = 0 in any cycle with no winner.
- Scoreboard:
  - pending[r] increments when issue_valid & issue_writes & !stall, with r = issue_dst.
  - pending[r] decrements when rf_write_enable=1 with rf_write_address = r (commit).
  - Increment and decrement of the same register in one cycle: net unchanged.
  - Counters never wrap.
- Stall is asserted when issue_valid and any of:
  - src1_used & pending[src1] != 0
  - src2_used & pending[src2] != 0
  - issue_writes & pending[issue_dst] == max (saturation guard)
- A commit in the current cycle does not clear a hazard until the next cycle (counters are registered), so there is no combinational bypass. Reading a register in the cycle after its commit returns new data, because the register file writes on posedge and reads on negedge.
- stall = 0 whenever issue_valid = 0.
- Writebacks to a register with pending = 0 (spurious) are still written. The counter stays at 0 and the simulation assertion flags it.
- Reset mid-operation: buffered ALU data is discarded; stall deasserts the cycle after reset.

Decomposition:
- Shared package pipeline_pkg holds:
  - DATA_WIDTH / ADDR_WIDTH constants
  - wb_req typedef {valid, addr, data}
  - arbitration-grant enum {GNT_NONE, GNT_MEM, GNT_BUF, GNT_ALU}
- One sub-module: wb_hold_buffer, the one-entry ALU holding register with full flag, load and drain controls.
- Scoreboard and arbiter stay in the top.

Test Plan:
- Reset: assert rst 2 cycles with all valids high -> rf_write_enable=0, stall=0, alu_wb_ready=1 after release, all counters 0.
- RAW stall: issue dst=3; next cycle issue src1=3 -> stall=1. ALU wb addr=3 data=0x00AA accepted -> rf_write_enable=1 addr=3 data=0x00AA one cycle later; stall drops the cycle after commit.
- Collision: mem addr=2 data=0x1111 and alu addr=5 data=0x2222 same cycle, buffer empty -> write 2/0x1111, then 5/0x2222 next cycle, alu_wb_ready=1 throughout.
- Back-pressure: buffer full (addr=5) and mem and alu (addr=6) valid -> alu_wb_ready=0. Write order: mem, then buffer(5), then 6.
- Saturation: issue dst=1 three times with no writeback -> fourth issue writing dst=1 stalls. One commit to 1 -> stall clears next cycle.
- Same-cycle inc/dec: pending[4]=1, commit to 4 while issuing dst=4 -> pending[4] stays 1, src read of 4 still stalls.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline types: default register-file geometry, writeback request record and
// write-port grant encoding.
package pipeline_pkg;

  localparam int unsigned DATA_WIDTH = 16;
  localparam int unsigned ADDR_WIDTH = 3;

  typedef struct packed {
    logic                  valid;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } wb_req;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_MEM,
    GNT_BUF,
    GNT_ALU
  } wb_grant_e;

endpackage

// File: rtl/wb_hold_buffer.sv
// One-entry holding register for an ALU writeback that lost the write port.
// A load in the same cycle as a drain refills the entry.
module wb_hold_buffer #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  drain,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic                  full,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] data
);

  logic                  full_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else if (load) begin
      full_q <= 1'b1;
      addr_q <= load_addr;
      data_q <= load_data;
    end else if (drain) begin
      full_q <= 1'b0;
    end
  end

  assign full = full_q;
  assign addr = addr_q;
  assign data = data_q;

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Register-file write-port arbiter (mem > held ALU > new ALU) plus a per-register
// scoreboard of in-flight writes that stalls decode on RAW hazards.
module regfile_wb_scheduler #(
  parameter int unsigned DATA_WIDTH = pipeline_pkg::DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = pipeline_pkg::ADDR_WIDTH,
  parameter int unsigned PEND_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_valid,
  input  logic                  issue_writes,
  input  logic [ADDR_WIDTH-1:0] issue_dst,
  input  logic                  src1_used,
  input  logic                  src2_used,
  input  logic [ADDR_WIDTH-1:0] src1,
  input  logic [ADDR_WIDTH-1:0] src2,
  output logic                  stall,
  input  logic                  alu_wb_valid,
  input  logic [ADDR_WIDTH-1:0] alu_wb_addr,
  input  logic [DATA_WIDTH-1:0] alu_wb_data,
  output logic                  alu_wb_ready,
  input  logic                  mem_wb_valid,
  input  logic [ADDR_WIDTH-1:0] mem_wb_addr,
  input  logic [DATA_WIDTH-1:0] mem_wb_data,
  output logic                  rf_write_enable,
  output logic [ADDR_WIDTH-1:0] rf_write_address,
  output logic [DATA_WIDTH-1:0] rf_write_data
);
  import pipeline_pkg::*;

  localparam int unsigned           NumRegs = 2 ** ADDR_WIDTH;
  localparam logic [PEND_WIDTH-1:0] PendMax = '1;

  // Write-port arbitration
  wb_grant_e             grant;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [DATA_WIDTH-1:0] win_data;
  logic                  buf_full;
  logic [ADDR_WIDTH-1:0] buf_addr;
  logic [DATA_WIDTH-1:0] buf_data;
  logic                  buf_load;
  logic                  buf_drain;

  always_comb begin
    grant    = GNT_NONE;
    win_addr = '0;
    win_data = '0;
    if (mem_wb_valid) begin
      grant    = GNT_MEM;
      win_addr = mem_wb_addr;
      win_data = mem_wb_data;
    end else if (buf_full) begin
      grant    = GNT_BUF;
      win_addr = buf_addr;
      win_data = buf_data;
    end else if (alu_wb_valid) begin
      grant    = GNT_ALU;
      win_addr = alu_wb_addr;
      win_data = alu_wb_data;
    end
  end

  assign alu_wb_ready = alu_wb_valid & (~buf_full | ~mem_wb_valid);
  // An accepted ALU result that did not win the port directly is parked.
  assign buf_load     = alu_wb_ready & (grant != GNT_ALU);
  assign buf_drain    = (grant == GNT_BUF);

  wb_hold_buffer #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_hold_buffer (
    .clk       (clk),
    .rst       (rst),
    .load      (buf_load),
    .drain     (buf_drain),
    .load_addr (alu_wb_addr),
    .load_data (alu_wb_data),
    .full      (buf_full),
    .addr      (buf_addr),
    .data      (buf_data)
  );

  logic                  wr_en_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [DATA_WIDTH-1:0] wr_data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q <= (grant != GNT_NONE);
      if (grant != GNT_NONE) begin
        wr_addr_q <= win_addr;
        wr_data_q <= win_data;
      end
    end
  end

  assign rf_write_enable  = wr_en_q;
  assign rf_write_address = wr_addr_q;
  assign rf_write_data    = wr_data_q;

  // Scoreboard
  logic [PEND_WIDTH-1:0] pending_q [NumRegs];
  logic [PEND_WIDTH-1:0] pending_d [NumRegs];
  logic                  issue_fire;

  always_comb begin
    stall = 1'b0;
    if (issue_valid) begin
      stall = (src1_used && (pending_q[src1] != '0)) ||
              (src2_used && (pending_q[src2] != '0)) ||
              (issue_writes && (pending_q[issue_dst] == PendMax));
    end
  end

  assign issue_fire = issue_valid & issue_writes & ~stall;

  always_comb begin
    logic inc;
    logic dec;
    inc = 1'b0;
    dec = 1'b0;
    for (int unsigned r = 0; r < NumRegs; r++) begin
      inc          = issue_fire && (issue_dst == ADDR_WIDTH'(r));
      dec          = wr_en_q && (wr_addr_q == ADDR_WIDTH'(r));
      pending_d[r] = pending_q[r];
      // Saturating in both directions; a same-cycle inc/dec cancels out.
      if (inc && !dec && (pending_q[r] != PendMax)) begin
        pending_d[r] = pending_q[r] + 1'b1;
      end else if (dec && !inc && (pending_q[r] != '0)) begin
        pending_d[r] = pending_q[r] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned r = 0; r < NumRegs; r++) begin
      if (rst) begin
        pending_q[r] <= '0;
      end else begin
        pending_q[r] <= pending_d[r];
      end
    end
  end

  // A commit to a register with nothing in flight means a writeback source misbehaved.
  spurious_wb_a : assert property (@(posedge clk) disable iff (rst)
    wr_en_q |-> (pending_q[wr_addr_q] != '0));

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed and randomized checks of regfile_wb_scheduler against a queue-based model of
// write ordering and per-register in-flight counts.
module tb_regfile_wb_scheduler;
  import pipeline_pkg::*;

  localparam int PendMax = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        issue_valid = 1'b0, issue_writes = 1'b0;
  logic [2:0]  issue_dst = '0, src1 = '0, src2 = '0;
  logic        src1_used = 1'b0, src2_used = 1'b0;
  logic        stall;
  logic        alu_wb_valid = 1'b0, mem_wb_valid = 1'b0;
  logic [2:0]  alu_wb_addr = '0, mem_wb_addr = '0;
  logic [15:0] alu_wb_data = '0, mem_wb_data = '0;
  logic        alu_wb_ready;
  logic        rf_write_enable;
  logic [2:0]  rf_write_address;
  logic [15:0] rf_write_data;

  regfile_wb_scheduler #(
    .DATA_WIDTH(16),
    .ADDR_WIDTH(3),
    .PEND_WIDTH(2)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .issue_valid      (issue_valid),
    .issue_writes     (issue_writes),
    .issue_dst        (issue_dst),
    .src1_used        (src1_used),
    .src2_used        (src2_used),
    .src1             (src1),
    .src2             (src2),
    .stall            (stall),
    .alu_wb_valid     (alu_wb_valid),
    .alu_wb_addr      (alu_wb_addr),
    .alu_wb_data      (alu_wb_data),
    .alu_wb_ready     (alu_wb_ready),
    .mem_wb_valid     (mem_wb_valid),
    .mem_wb_addr      (mem_wb_addr),
    .mem_wb_data      (mem_wb_data),
    .rf_write_enable  (rf_write_enable),
    .rf_write_address (rf_write_address),
    .rf_write_data    (rf_write_data)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: in-flight writes per register, ALU results waiting for the port,
  // and the write expected on the port after the coming edge.
  int    pend [8];
  wb_req held [$];
  logic  m_we;
  int    m_addr;
  int    m_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_clear();
    foreach (pend[r]) pend[r] = 0;
    held.delete();
    m_we = 1'b0;
    m_addr = 0;
    m_data = 0;
  endtask

  task automatic step(input logic iv, input logic iw, input int dst,
                      input logic s1u, input int s1, input logic s2u, input int s2,
                      input logic av, input int aa, input int ad,
                      input logic mv, input int ma, input int md,
                      output logic rec, output logic acc);
    logic  e_stall, e_ready, had_held;
    wb_req nw, alu_item;
    @(negedge clk);
    issue_valid = iv;  issue_writes = iw;  issue_dst = 3'(dst);
    src1_used = s1u;   src1 = 3'(s1);      src2_used = s2u;  src2 = 3'(s2);
    alu_wb_valid = av; alu_wb_addr = 3'(aa); alu_wb_data = 16'(ad);
    mem_wb_valid = mv; mem_wb_addr = 3'(ma); mem_wb_data = 16'(md);
    #1;
    e_stall = iv && ((s1u && pend[s1] != 0) || (s2u && pend[s2] != 0) ||
                     (iw && pend[dst] == PendMax));
    e_ready = av && (held.size() == 0 || !mv);
    check("stall", 32'(stall), 32'(e_stall));
    check("alu_wb_ready", 32'(alu_wb_ready), 32'(e_ready));
    rec = iv && iw && !e_stall;
    acc = e_ready;
    if (rec) pend[dst]++;
    if (m_we && pend[m_addr] > 0) pend[m_addr]--;
    // Port order: load result first, then the oldest waiting ALU result, then a new one.
    alu_item.valid = 1'b1;
    alu_item.addr  = 3'(aa);
    alu_item.data  = 16'(ad);
    had_held = (held.size() != 0);
    nw.valid = 1'b1;
    nw.addr  = 3'(ma);
    nw.data  = 16'(md);
    if (!mv) begin
      if (had_held) nw = held.pop_front();
      else if (av) nw = alu_item;
      else nw.valid = 1'b0;
    end
    if (e_ready && (mv || had_held)) held.push_back(alu_item);
    m_we   = nw.valid;
    m_addr = int'(nw.addr);
    m_data = int'(nw.data);
    @(posedge clk);
    #1;
    check("rf_write_enable", 32'(rf_write_enable), 32'(m_we));
    if (m_we) begin
      check("rf_write_address", 32'(rf_write_address), 32'(m_addr));
      check("rf_write_data", 32'(rf_write_data), 32'(m_data));
    end
  endtask

  task automatic iss(input int d);
    logic r, a;
    step(1, 1, d, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, r, a);
  endtask

  task automatic idle();
    logic r, a;
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, r, a);
  endtask

  task automatic alu_wb(input int a, input int d);
    logic r, x;
    step(0, 0, 0, 0, 0, 0, 0, 1, a, d, 0, 0, 0, r, x);
  endtask

  // Reads every register through both source ports; any nonzero count would stall.
  task automatic probe_all_clear();
    logic r, a;
    for (int i = 0; i < 8; i++) step(1, 0, 0, 1, i, 1, (i + 1) % 8, 0, 0, 0, 0, 0, 0, r, a);
  endtask

  task automatic do_reset(input int cycles, input logic vhigh);
    @(negedge clk);
    rst = 1'b1;
    issue_valid = vhigh; issue_writes = vhigh; src1_used = vhigh; src2_used = vhigh;
    alu_wb_valid = vhigh; mem_wb_valid = vhigh;
    repeat (cycles) @(posedge clk);
    #1;
    check("reset_we", 32'(rf_write_enable), 32'd0);
    check("reset_addr", 32'(rf_write_address), 32'd0);
    check("reset_data", 32'(rf_write_data), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  initial begin : main
    logic r, a;
    int   owed [$];
    logic alu_busy;
    int   alu_a, alu_d;

    model_clear();
    // Reset with every request held high; after release nothing is in flight.
    do_reset(2, 1'b1);
    #1;
    check("post_reset_stall", 32'(stall), 32'd0);
    check("post_reset_ready", 32'(alu_wb_ready), 32'd1);
    issue_valid = 1'b0; alu_wb_valid = 1'b0; mem_wb_valid = 1'b0;
    probe_all_clear();

    // RAW hazard cleared by an ALU commit.
    iss(3);
    step(1, 0, 0, 1, 3, 0, 0, 1, 3, 'h00AA, 0, 0, 0, r, a);
    step(1, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, r, a);
    step(1, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, r, a);

    // Mem/ALU collision with an empty buffer.
    iss(2); iss(5);
    step(0, 0, 0, 0, 0, 0, 0, 1, 5, 'h2222, 1, 2, 'h1111, r, a);
    idle(); idle();

    // Back-pressure with the buffer full.
    iss(7); iss(7); iss(5); iss(6);
    step(0, 0, 0, 0, 0, 0, 0, 1, 5, 'h5555, 1, 7, 'h7001, r, a);
    step(0, 0, 0, 0, 0, 0, 0, 1, 6, 'h6666, 1, 7, 'h7002, r, a);
    step(0, 0, 0, 0, 0, 0, 0, 1, 6, 'h6666, 0, 0, 0, r, a);
    idle(); idle();

    // Counter saturation guard.
    iss(1); iss(1); iss(1);
    step(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, r, a);
    step(1, 1, 1, 0, 0, 0, 0, 1, 1, 'h0101, 0, 0, 0, r, a);
    step(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, r, a);
    step(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, r, a);
    check("sat_issue_recorded", 32'(r), 32'd1);
    alu_wb(1, 'h0102); alu_wb(1, 'h0103); alu_wb(1, 'h0104);
    idle(); idle();

    // Same-cycle increment and decrement of one register.
    iss(4);
    alu_wb(4, 'h4444);
    step(1, 1, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, r, a);
    step(1, 0, 0, 1, 4, 0, 0, 0, 0, 0, 0, 0, 0, r, a);
    alu_wb(4, 'h4445);
    idle(); idle();
    probe_all_clear();

    // Randomized traffic; writebacks only target registers with an outstanding issue.
    alu_busy = 1'b0;
    alu_a = 0;
    alu_d = 0;
    for (int c = 0; c < 500; c++) begin
      logic iv, iw, s1u, s2u, mv;
      int   dst, s1, s2, ma, md;
      iv  = ($urandom_range(0, 3) != 0);
      iw  = ($urandom_range(0, 2) != 0);
      s1u = $urandom_range(0, 1);
      s2u = ($urandom_range(0, 3) == 0);
      dst = $urandom_range(0, 7);
      s1  = $urandom_range(0, 7);
      s2  = $urandom_range(0, 7);
      if (!alu_busy && owed.size() > 0 && $urandom_range(0, 1) == 1) begin
        alu_a = owed.pop_front();
        alu_d = $urandom_range(0, 65535);
        alu_busy = 1'b1;
      end
      mv = 1'b0; ma = 0; md = 0;
      if (owed.size() > 0 && $urandom_range(0, 2) == 0) begin
        ma = owed.pop_front();
        md = $urandom_range(0, 65535);
        mv = 1'b1;
      end
      step(iv, iw, dst, s1u, s1, s2u, s2, alu_busy, alu_a, alu_d, mv, ma, md, r, a);
      if (a) alu_busy = 1'b0;
      if (r) owed.push_back(dst);
    end
    for (int c = 0; c < 200 && (owed.size() > 0 || alu_busy); c++) begin
      logic mv;
      int   ma;
      if (!alu_busy && owed.size() > 0) begin
        alu_a = owed.pop_front();
        alu_d = $urandom_range(0, 65535);
        alu_busy = 1'b1;
      end
      mv = 1'b0; ma = 0;
      if (owed.size() > 0 && $urandom_range(0, 1) == 1) begin
        ma = owed.pop_front();
        mv = 1'b1;
      end
      step(0, 0, 0, 0, 0, 0, 0, alu_busy, alu_a, alu_d, mv, ma, 'h0BAD, r, a);
      if (a) alu_busy = 1'b0;
    end
    check("drain_done", 32'(owed.size()) + 32'(alu_busy), 32'd0);
    idle(); idle();
    probe_all_clear();

    // Reset while an ALU result is parked: it must never reach the port.
    iss(2); iss(2);
    step(0, 0, 0, 0, 0, 0, 0, 1, 2, 'h2BAD, 1, 2, 'h2001, r, a);
    do_reset(1, 1'b0);
    idle(); idle(); idle();
    probe_all_clear();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1);
  end

endmodule
